shift_sub_divider: RTL and testbench

Sequential restoring divider: 6-bit unsigned dividend by 3-bit unsigned divisor. Produces a 6-bit quotient and a 3-bit remainder, one quotient bit per clock. It is the inverse of the 3x3 array multiplier. It sits between the button-memory operand registers and the LED/LCD display path, so a multiplied product can be divided back into its factors on the board.

---
 rtl/shift_sub_divider.sv | 73 +++++++
 tb/tb_shift_sub_divider.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring divider, 6-bit unsigned dividend by 3-bit unsigned divisor, one quotient bit per clock
// Ports: clk, reset (async active-low), start -> accepts dividend[5:0]/divisor[2:0] in IDLE;
//        busy (RUN), done (1-cycle pulse), quotient[5:0], remainder[2:0], div_zero (held until next accepted start)
module shift_sub_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] dividend,
  input  logic [2:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [5:0] quotient,
  output logic [2:0] remainder,
  output logic       div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [2:0] p, d, cnt, p_n;
  logic [5:0] q, q_n;
  logic [3:0] t;
  logic ge, zp, accept;
  // zp marks an accepted divide-by-zero; it waits one IDLE cycle so done rises one edge after acceptance
  assign accept = state == IDLE && start && !zp;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    t = {p, q[5]};
    ge = t >= {1'b0, d};
    p_n = ge ? 3'(t - {1'b0, d}) : t[2:0];
    q_n = {q[4:0], ge};
    nxt = state;
    if (state == IDLE) nxt = zp ? DONE : (start && divisor != 3'd0) ? RUN : IDLE;
    else if (state == RUN) nxt = cnt == 3'd5 ? DONE : RUN;
    else nxt = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      p <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      zp <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        p <= '0;
        q <= dividend;
        d <= divisor;
        cnt <= '0;
        zp <= divisor == 3'd0;
        quotient <= '0;
        remainder <= '0;
        div_zero <= 1'b0;
      end else if (zp) begin
        zp <= 1'b0;
        quotient <= 6'h3F;
        remainder <= '0;
        div_zero <= 1'b1;
      end else if (state == RUN) begin
        p <= p_n;
        q <= q_n;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd5) begin
          quotient <= q_n;
          remainder <= p_n;
        end
      end
    end
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider: directed checks of the restoring divider
module tb_shift_sub_divider;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [5:0] dividend = '0, quotient;
  logic [2:0] divisor = '0, remainder;
  logic busy, done, div_zero;
  int checks = 0, errors = 0;
  int lat, n;
  bit saw_busy;
  shift_sub_divider dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int k, output bit sb);
    k = 0;
    sb = 1'b0;
    while (!done && k < 20) begin
      sb |= busy;
      @(negedge clk);
      k++;
    end
    sb |= busy;
  endtask
  task automatic op(input logic [5:0] dd, input logic [2:0] dv, output int k, output bit sb);
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, sb);
  endtask
  task automatic check_op(input string tag, input logic [5:0] dd, input logic [2:0] dv,
                          input int eq, input int er, input int ez, input int el);
    op(dd, dv, lat, saw_busy);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, div_zero, ez);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_busy_seen"}, saw_busy, ez == 0);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_hold_q"}, quotient, eq);
    chk({tag, "_hold_r"}, remainder, er);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_zero, 0);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1; dividend = 6'd63; divisor = 3'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    @(negedge clk);
    reset = 1'b1;
    check_op("d42_5", 6'd42, 3'd5, 8, 2, 0, 6);
    check_op("d63_7", 6'd63, 3'd7, 9, 0, 0, 6);
    check_op("d5_6", 6'd5, 3'd6, 0, 5, 0, 6);
    check_op("d0_3", 6'd0, 3'd3, 0, 0, 0, 6);
    check_op("d17_0", 6'd17, 3'd0, 63, 0, 1, 1);
    check_op("d17_1", 6'd17, 3'd1, 17, 0, 0, 6);
    @(negedge clk);
    start = 1'b1; dividend = 6'd42; divisor = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 6'd9; divisor = 3'd3;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", busy, 1);
    wait_done(lat, saw_busy);
    chk("ign_lat", lat, 4);
    chk("ign_q", quotient, 8);
    chk("ign_r", remainder, 2);
    @(negedge clk);
    start = 1'b1; dividend = 6'd42; divisor = 3'd5;
    @(negedge clk);
    wait_done(lat, saw_busy);
    chk("b2b_first_lat", lat, 6);
    @(negedge clk);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_spacing", n, 8);
    chk("b2b_q", quotient, 8);
    chk("b2b_r", remainder, 2);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_idle", busy, 0);
    @(negedge clk);
    start = 1'b1; dividend = 6'd50; divisor = 3'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("e3_rst_busy", busy, 0);
    chk("e3_rst_q", quotient, 0);
    chk("e3_rst_z", div_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(done);
    end
    chk("e3_no_done", n, 0);
    check_op("d50_4", 6'd50, 3'd4, 12, 2, 0, 6);
    for (int a = 0; a < 64; a++)
      for (int b = 1; b < 8; b++) begin
        op(6'(a), 3'(b), lat, saw_busy);
        chk("sweep_lat", lat, 6);
        chk("sweep_identity", int'(quotient) * b + int'(remainder), a);
        chk("sweep_rem_lt", remainder < 3'(b), 1);
        @(negedge clk);
        chk("sweep_once", done, 0);
      end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
